// File: rtl/prod_matrix_launcher.sv
// rtl/prod_matrix_launcher.sv - job queue and call sequencer for the prod_matrix component
module prod_matrix_launcher #(
   parameter int QDEPTH     = 4,
   parameter int SLOW_LIMIT = 100000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [63:0] job_v,
   input  logic [63:0] job_r,
   input  logic [31:0] job_row,
   input  logic [31:0] job_col,
   output logic        pm_start,
   input  logic        pm_busy,
   input  logic        pm_done,
   output logic        pm_stall,
   output logic [63:0] pm_v,
   output logic [63:0] pm_r,
   output logic [31:0] pm_row,
   output logic [31:0] pm_col,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [7:0]  res_id,
   output logic [31:0] res_cycles,
   output logic        res_slow,
   output logic        res_skip,
   output logic [4:0]  pending
);

   localparam int          AW    = $clog2(QDEPTH);
   localparam logic [4:0]  DEPTH = 5'(QDEPTH);
   localparam logic [31:0] SLOW  = 32'(SLOW_LIMIT);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_CALL   = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_REPORT = 3'd4;

   // Queue entry layout: {v, r, row, col}
   logic [191:0]  mem_q [QDEPTH];
   logic [191:0]  mem_d [QDEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]    count_q, count_d;

   logic [2:0]    state_q, state_d;
   logic [63:0]   v_q, v_d, r_q, r_d;
   logic [31:0]   row_q, row_d, col_q, col_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [31:0]   cyc_q, cyc_d;
   logic          slow_q, slow_d;
   logic          skip_q, skip_d;
   logic [7:0]    id_q, id_d;

   logic          push, pop;
   logic [31:0]   cnt_inc;

   // Occupancy alone decides readiness, so a same-cycle pop never frees a full queue
   assign job_ready = (count_q < DEPTH);
   assign push      = job_valid && job_ready;
   assign pop       = (state_q == S_IDLE) && (count_q != 5'd0);
   assign cnt_inc   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

   assign pm_start   = (state_q == S_CALL);
   assign pm_stall   = (state_q != S_RUN);
   assign pm_v       = v_q;
   assign pm_r       = r_q;
   assign pm_row     = row_q;
   assign pm_col     = col_q;
   assign res_valid  = (state_q == S_REPORT);
   assign res_id     = id_q;
   assign res_cycles = cyc_q;
   assign res_slow   = slow_q;
   assign res_skip   = skip_q;
   assign pending    = count_q;

   // Queue storage, pointers and occupancy next-state
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {job_v, job_r, job_row, job_col};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase
   end

   // Call sequencer: pop, screen degenerate jobs, call, time, report
   always_comb begin
      state_d = state_q;
      v_d     = v_q;
      r_d     = r_q;
      row_d   = row_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      cyc_d   = cyc_q;
      slow_d  = slow_q;
      skip_d  = skip_q;
      id_d    = id_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               {v_d, r_d, row_d, col_d} = mem_q[rd_ptr_q];
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (row_q == 32'd0 || col_q == 32'd0) begin
               cyc_d   = 32'd0;
               slow_d  = 1'b0;
               skip_d  = 1'b1;
               state_d = S_REPORT;
            end else begin
               state_d = S_CALL;
            end
         end
         S_CALL: begin
            if (!pm_busy) begin
               cnt_d   = 32'd0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (pm_done) begin
               cyc_d   = cnt_inc;
               slow_d  = (cnt_inc >= SLOW);
               skip_d  = 1'b0;
               state_d = S_REPORT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_REPORT: begin
            if (res_ready) begin
               id_d    = id_q + 8'd1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Queue payload registers; contents are don't-care while empty, so no reset
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   // Control and result registers
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= S_IDLE;
         v_q      <= '0;
         r_q      <= '0;
         row_q    <= '0;
         col_q    <= '0;
         cnt_q    <= '0;
         cyc_q    <= '0;
         slow_q   <= 1'b0;
         skip_q   <= 1'b0;
         id_q     <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         v_q      <= v_d;
         r_q      <= r_d;
         row_q    <= row_d;
         col_q    <= col_d;
         cnt_q    <= cnt_d;
         cyc_q    <= cyc_d;
         slow_q   <= slow_d;
         skip_q   <= skip_d;
         id_q     <= id_d;
      end
   end

endmodule

// File: tb/tb_prod_matrix_launcher.sv
// tb/tb_prod_matrix_launcher.sv - self-checking bench for prod_matrix_launcher
module tb_prod_matrix_launcher;

   localparam int QD = 4;
   localparam int SL = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        job_valid = 1'b0;
   logic        job_ready;
   logic [63:0] job_v = '0, job_r = '0;
   logic [31:0] job_row = '0, job_col = '0;
   logic        pm_start, pm_stall;
   logic        pm_busy = 1'b0, pm_done = 1'b0;
   logic [63:0] pm_v, pm_r;
   logic [31:0] pm_row, pm_col;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [7:0]  res_id;
   logic [31:0] res_cycles;
   logic        res_slow, res_skip;
   logic [4:0]  pending;

   always #5 clock = ~clock;

   prod_matrix_launcher #(.QDEPTH(QD), .SLOW_LIMIT(SL)) dut (
      .clock(clock), .reset(reset),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_v(job_v), .job_r(job_r), .job_row(job_row), .job_col(job_col),
      .pm_start(pm_start), .pm_busy(pm_busy), .pm_done(pm_done), .pm_stall(pm_stall),
      .pm_v(pm_v), .pm_r(pm_r), .pm_row(pm_row), .pm_col(pm_col),
      .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
      .res_cycles(res_cycles), .res_slow(res_slow), .res_skip(res_skip),
      .pending(pending)
   );

   typedef struct {
      logic [63:0] v;
      logic [63:0] r;
      logic [31:0] row;
      logic [31:0] col;
      int          delay;
      int          busy;
   } call_t;

   typedef struct {
      logic [7:0]  id;
      logic [31:0] cycles;
      logic        slow;
      logic        skip;
   } res_t;

   call_t call_q[$];
   res_t  exp_q[$];
   int    total = 0;
   int    bad = 0;
   int    next_id = 0;
   int    n_res = 0;
   bit    noise = 1'b0;
   int    rdy_pct = 100;

   task automatic chk(string tag, logic [191:0] obs, logic [191:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Component model: honours per-job busy/latency and checks call-side behaviour
   call_t cc;
   bit    prev_start = 1'b0, exp_run = 1'b0, exp_call = 1'b0;
   int    busy_left = 0, run_k = 0;
   always @(negedge clock) begin
      if (reset) begin
         pm_busy = 1'b0; pm_done = 1'b0; prev_start = 1'b0;
         exp_run = 1'b0; exp_call = 1'b0; run_k = 0;
      end else begin
         if (exp_run) begin
            chk("run_entered", 192'({pm_start, pm_stall}), 192'(0));
            exp_run = 1'b0;
         end
         if (exp_call) begin
            chk("call_held", 192'(pm_start), 192'(1));
            exp_call = 1'b0;
         end
         pm_done = 1'b0;
         if (pm_start) begin
            if (!prev_start) begin
               chk("call_expected", 192'(call_q.size() > 0), 192'(1));
               if (call_q.size() > 0) cc = call_q.pop_front();
               busy_left = cc.busy;
            end
            chk("call_args", {pm_v, pm_r, pm_row, pm_col}, {cc.v, cc.r, cc.row, cc.col});
            if (busy_left > 0) begin
               pm_busy = 1'b1; busy_left--; exp_call = 1'b1;
            end else begin
               pm_busy = 1'b0; exp_run = 1'b1; run_k = 0;
            end
         end else if (!pm_stall) begin
            run_k++;
            chk("run_args", {pm_v, pm_r, pm_row, pm_col}, {cc.v, cc.r, cc.row, cc.col});
            pm_done = (run_k == cc.delay);
         end else begin
            pm_busy = 1'($urandom_range(0, 1));
            pm_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         prev_start = pm_start;
      end
   end

   // Result sink: compares each result with the model and applies random back-pressure
   res_t        cur;
   bit          seen = 1'b0;
   logic [41:0] held;
   always @(negedge clock) begin
      if (reset) begin
         res_ready = 1'b0; seen = 1'b0; n_res = 0;
      end else if (res_valid) begin
         if (!seen) begin
            chk("result_expected", 192'(exp_q.size() > 0), 192'(1));
            if (exp_q.size() > 0) begin
               cur = exp_q[0];
               chk("res_id", 192'(res_id), 192'(cur.id));
               chk("res_cycles", 192'(res_cycles), 192'(cur.cycles));
               chk("res_slow", 192'(res_slow), 192'(cur.slow));
               chk("res_skip", 192'(res_skip), 192'(cur.skip));
            end
            held = {res_id, res_cycles, res_slow, res_skip};
            seen = 1'b1;
         end else begin
            chk("res_stable", 192'({res_id, res_cycles, res_slow, res_skip}), 192'(held));
         end
         if (int'($urandom_range(1, 100)) <= rdy_pct) begin
            res_ready = 1'b1;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            seen = 1'b0;
            n_res++;
         end else begin
            res_ready = 1'b0;
         end
      end else begin
         res_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic push_job(logic [63:0] v, logic [63:0] r, logic [31:0] row, logic [31:0] col,
                           int delay, int busy);
      int    g = 0;
      bit    sk;
      res_t  e;
      call_t c;
      job_v = v; job_r = r; job_row = row; job_col = col; job_valid = 1'b1;
      while (!job_ready && g < 3000) begin
         @(negedge clock);
         g++;
      end
      chk("push_accept", 192'(job_ready), 192'(1));
      sk       = (row == 0) || (col == 0);
      e.id     = 8'(next_id);
      e.cycles = sk ? 32'd0 : 32'(delay);
      e.slow   = !sk && (delay >= SL);
      e.skip   = sk;
      exp_q.push_back(e);
      if (!sk) begin
         c.v = v; c.r = r; c.row = row; c.col = col; c.delay = delay; c.busy = busy;
         call_q.push_back(c);
      end
      next_id = (next_id + 1) % 256;
      @(negedge clock);
      job_valid = 1'b0;
   endtask

   task automatic drain(int limit);
      int g = 0;
      while (exp_q.size() != 0 && g < limit) begin
         @(negedge clock);
         g++;
      end
      chk("drain", 192'(exp_q.size()), 192'(0));
      @(negedge clock);
   endtask

   task automatic wait_run(int limit);
      int g = 0;
      while (pm_stall && g < limit) begin
         @(negedge clock);
         g++;
      end
      chk("wait_run", 192'(pm_stall), 192'(0));
   endtask

   task automatic do_reset();
      @(posedge clock);
      #1;
      reset = 1'b1;
      job_valid = 1'b0;
      exp_q.delete();
      call_q.delete();
      next_id = 0;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   function automatic logic [31:0] dim();
      return ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk("rst_pm_start", 192'(pm_start), 192'(0));
      chk("rst_res_valid", 192'(res_valid), 192'(0));
      chk("rst_res_flags", 192'({res_slow, res_skip}), 192'(0));
      chk("rst_res_cycles", 192'(res_cycles), 192'(0));
      chk("rst_res_id", 192'(res_id), 192'(0));
      chk("rst_pending", 192'(pending), 192'(0));
      chk("rst_args", {pm_v, pm_r, pm_row, pm_col}, 192'(0));
      chk("rst_pm_stall", 192'(pm_stall), 192'(1));
      chk("rst_job_ready", 192'(job_ready), 192'(1));
      reset = 1'b0;
      @(negedge clock);

      // single job, 10-cycle call
      push_job(64'h1000, 64'h2000, 32'd3, 32'd3, 10, 0);
      drain(200);

      // back-pressure: five busy cycles in CALL
      push_job({$urandom, $urandom}, {$urandom, $urandom}, 32'd4, 32'd5, 6, 5);
      drain(200);

      // skipped jobs never call the component
      push_job(64'h11, 64'h22, 32'd0, 32'd7, 5, 0);
      push_job(64'h33, 64'h44, 32'd9, 32'd0, 5, 0);
      drain(200);

      // slow threshold boundary and minimum latency
      push_job(64'h55, 64'h66, 32'd2, 32'd2, 8, 0);
      push_job(64'h77, 64'h88, 32'd2, 32'd2, 7, 0);
      push_job(64'h99, 64'haa, 32'd2, 32'd2, 1, 0);
      drain(300);

      // queue full while first call is running
      do_reset();
      @(negedge clock);
      push_job(64'hA0, 64'hB0, 32'd3, 32'd3, 60, 0);
      wait_run(50);
      for (int i = 0; i < 4; i++)
         push_job({$urandom, $urandom}, {$urandom, $urandom}, 32'(i + 1), 32'd2, 3 + i, i % 2);
      chk("full_pending", 192'(pending), 192'(4));
      chk("full_ready", 192'(job_ready), 192'(0));
      repeat (3) @(negedge clock);
      chk("full_hold", 192'({pending, job_ready}), 192'({5'd4, 1'b0}));
      push_job(64'hC0, 64'hD0, 32'd5, 32'd5, 4, 0);
      drain(2000);

      // randomized mix with done noise and result back-pressure
      noise = 1'b1;
      rdy_pct = 60;
      for (int i = 0; i < 40; i++)
         push_job({$urandom, $urandom}, {$urandom, $urandom}, dim(), dim(),
                  int'($urandom_range(1, 20)), int'($urandom_range(0, 3)));
      drain(5000);
      noise = 1'b0;
      rdy_pct = 100;

      // res_id wrap after 256 results
      do_reset();
      @(negedge clock);
      for (int i = 0; i < 258; i++)
         push_job(64'(i), 64'(i), 32'd0, 32'(i), 1, 0);
      drain(3000);
      chk("wrap_count", 192'(n_res), 192'(258));
      chk("wrap_id", 192'(res_id), 192'(2));

      // reset during RUN abandons the call and the queue
      push_job(64'hE0, 64'hF0, 32'd2, 32'd2, 500, 0);
      wait_run(50);
      push_job(64'h1, 64'h2, 32'd1, 32'd1, 5, 0);
      push_job(64'h3, 64'h4, 32'd1, 32'd1, 5, 0);
      chk("mr_pending_before", 192'(pending), 192'(2));
      do_reset();
      chk("mr_pending", 192'(pending), 192'(0));
      chk("mr_pm_start", 192'(pm_start), 192'(0));
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("mr_no_result", 192'({res_valid, pm_start}), 192'(0));
      end
      push_job(64'h1000, 64'h2000, 32'd3, 32'd3, 10, 0);
      drain(200);
      chk("mr_next_id", 192'(res_id), 192'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
